lsu: RTL and testbench
======================

# lsu

Load/store unit forming the memory stage directly downstream of the execute unit. Latches the execute-stage load/store address, store operand and destination register, issues one request at a time to the data-memory port, and returns aligned, sign- or zero-extended load data to writeback. Stalls upstream while an access is outstanding and honours branch-redirect flushes.

## Interface
- `DATA_WIDTH`, 64: data and address width.
- `clock` in 1: sole clock.
- `reset_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: execute stage presents a load or store.
- `in_ready` out 1: lsu can accept; high only in IDLE.
- `is_load`, `is_store` in 1: access kind; exactly one is high when `in_valid`.
- `ls_size` in 4: one-hot size; bit0 byte, bit1 half, bit2 word, bit3 double; lowest set bit wins.
- `is_unsigned` in 1: zero-extend load data.
- `ls_address` in DATA_WIDTH: byte address.
- `store_data` in DATA_WIDTH: store operand in the low bytes.
- `rd` in 5: destination logical register.
- `flush` in 1: redirect from the branch unit; kills the in-flight access.
- `mem_req_valid` out 1, `mem_req_ready` in 1: request handshake.
- `mem_req_addr` out DATA_WIDTH: address with low 3 bits zeroed.
- `mem_req_wen` out 1: store.
- `mem_req_wmask` out 8: byte-enable mask.
- `mem_req_wdata` out DATA_WIDTH: store data shifted into lane position.
- `mem_resp_valid` in 1, `mem_resp_rdata` in DATA_WIDTH: single-cycle response, always accepted.
- `wb_valid` out 1, `wb_rd` out 5, `wb_data` out DATA_WIDTH: load writeback, one-cycle pulse.
- `misalign_valid` out 1, `misalign_addr` out DATA_WIDTH: misalignment report, only with LSU_MISALIGN_CHECK_EN.

## Operation
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE: on `in_valid`, latch all inputs and go to REQ.
- REQ: `mem_req_valid`=1. Go to WAIT on `mem_req_ready`. On `flush`, go to IDLE with no request issued; flush takes priority over a same-cycle ready.
- WAIT: on `mem_resp_valid`, a load drives `wb_*` the next cycle; a store produces no writeback. Go to IDLE. A `flush` in WAIT without a response goes to DRAIN.
- DRAIN: consume the response and suppress writeback, then go to IDLE. A flush together with the response goes straight to IDLE with no writeback.
- Lane offset is `addr[2:0]`.
- wmask: byte `1<<off`; half `3<<off`; word `0xF<<off`; double `0xFF`.
- Load data: `rdata >> (8*off)`, truncated to size, then sign- or zero-extended to 64 bits.
- Misaligned: half with odd offset; word with `off[1:0]`≠0; double with `off`≠0.

## Timing
- Reset values: all outputs 0, `in_ready`=1, state IDLE, latched registers 0.
- Cycle 0: accept. Cycle 1: request; ready may arrive in the same cycle. Response no earlier than cycle 2. `wb_valid` one cycle after the response.
- Minimum load-to-writeback latency is 3 cycles.
- `in_ready` rises the cycle after the response, so a new access may be accepted in the same cycle `wb_valid` is high.
- `mem_req_*` are registered and held stable until ready.
- `flush` while in IDLE is ignored.
- `reset_n` low mid-access returns to IDLE next edge; any pending memory response is discarded.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined: a misaligned access issues no memory request. It pulses `misalign_valid` for one cycle, with `misalign_addr` = the address, in the cycle after accept, then returns to IDLE.
- Not defined: no check. The address is used as-is with only 8-byte aligned addressing. Lanes that would cross the 8-byte boundary are dropped by the shift. `misalign_*` are tied to 0.

## Structure
- Add to `defines.sv`: `LS_SIZE_*` bit indices, an `LSU_STATE` 2-bit encoding, and reuse `RESULT_RANGE` / `LREG_RANGE`.
- One combinational sub-module, `load_extend`: inputs are rdata, offset, size and unsigned; output is the 64-bit writeback value.

## Test plan
- Load word signed at 0x1004, rdata 0x80000000_00000000 -> wb_data 0xFFFFFFFF_80000000, wb_valid in cycle 3 with ready and response immediate.
- Store half 0xABCD at 0x2006 -> wmask 0xC0, wdata 0xABCD0000_00000000, addr 0x2000, no wb_valid.
- Load byte unsigned at 0x3003 with ready held low for 4 cycles -> request held stable, then rdata 0x00000000_FE000000 gives wb_data 0xFE.
- Flush in WAIT, response 2 cycles later -> DRAIN, no wb_valid, in_ready returns the cycle after the response.
- With the macro defined, load double at 0x4004 -> misalign_valid pulse with 0x4004, no mem_req_valid. Without the macro, the request issues to 0x4000.
- Back-to-back loads to 0x0 and 0x8 -> second accepted in the same cycle as the first wb_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access size decode,
// byte-enable generation and alignment test.
package lsu_pkg;

  localparam int LREG_W = 5;
  localparam int LS_SIZE_BYTE   = 0;
  localparam int LS_SIZE_HALF   = 1;
  localparam int LS_SIZE_WORD   = 2;
  localparam int LS_SIZE_DOUBLE = 3;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_REQ   = 2'd1,
    LSU_WAIT  = 2'd2,
    LSU_DRAIN = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  // Lowest set bit wins; an empty size vector falls back to byte.
  function automatic size_e decode_size(input logic [3:0] ls_size);
    if (ls_size[LS_SIZE_BYTE]) return SZ_B;
    else if (ls_size[LS_SIZE_HALF]) return SZ_H;
    else if (ls_size[LS_SIZE_WORD]) return SZ_W;
    else if (ls_size[LS_SIZE_DOUBLE]) return SZ_D;
    else return SZ_B;
  endfunction

  function automatic logic [7:0] byte_mask(input size_e sz, input logic [2:0] off);
    case (sz)
      SZ_B:    return 8'h01 << off;
      SZ_H:    return 8'h03 << off;
      SZ_W:    return 8'h0F << off;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [2:0] off);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return off[1:0] != 2'b00;
      default: return off != 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load alignment: shifts the memory word down by the lane
// offset, truncates to the access size and sign- or zero-extends.
module load_extend
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [2:0]            offset,
  input  size_e                 size,
  input  logic                  is_unsigned,
  output logic [DATA_WIDTH-1:0] result
);

  logic [DATA_WIDTH-1:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    result = shifted;
    case (size)
      SZ_B: result = {{(DATA_WIDTH-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_H: result = {{(DATA_WIDTH-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
      SZ_W: result = {{(DATA_WIDTH-32){~is_unsigned & shifted[31]}}, shifted[31:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Memory-stage load/store unit: one outstanding data-memory access at a time,
// flush-aware. Define LSU_MISALIGN_CHECK_EN to trap misaligned accesses.
module lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [3:0]            ls_size,
  input  logic                  is_unsigned,
  input  logic [DATA_WIDTH-1:0] ls_address,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [LREG_W-1:0]     rd,
  input  logic                  flush,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_wen,
  output logic [7:0]            mem_req_wmask,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
  output logic                  wb_valid,
  output logic [LREG_W-1:0]     wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  misalign_valid,
  output logic [DATA_WIDTH-1:0] misalign_addr
);

  lsu_state_e            state_q, state_d;
  size_e                 size_q, size_d, in_sz;
  logic [2:0]            off_q, off_d, in_off;
  logic                  unsigned_q, unsigned_d;
  logic                  load_q, load_d;
  logic [LREG_W-1:0]     rd_q, rd_d;
  logic [DATA_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                  wen_q, wen_d;
  logic [7:0]            wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [LREG_W-1:0]     wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [DATA_WIDTH-1:0] ext_data;
`ifdef LSU_MISALIGN_CHECK_EN
  logic                  mis_valid_q, mis_valid_d;
  logic [DATA_WIDTH-1:0] mis_addr_q, mis_addr_d;
`endif

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
    .rdata       (mem_resp_rdata),
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .result      (ext_data)
  );

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    off_d      = off_q;
    unsigned_d = unsigned_q;
    load_d     = load_q;
    rd_d       = rd_q;
    req_addr_d = req_addr_q;
    wen_d      = wen_q;
    wmask_d    = wmask_q;
    wdata_d    = wdata_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
`ifdef LSU_MISALIGN_CHECK_EN
    mis_valid_d = 1'b0;
    mis_addr_d  = mis_addr_q;
`endif
    in_sz  = decode_size(ls_size);
    in_off = ls_address[2:0];

    case (state_q)
      LSU_IDLE: begin
        if (in_valid) begin
          size_d     = in_sz;
          off_d      = in_off;
          unsigned_d = is_unsigned;
          load_d     = is_load;
          rd_d       = rd;
          req_addr_d = {ls_address[DATA_WIDTH-1:3], 3'b000};
          wen_d      = is_store;
          wmask_d    = byte_mask(in_sz, in_off);
          wdata_d    = store_data << {in_off, 3'b000};
          state_d    = LSU_REQ;
`ifdef LSU_MISALIGN_CHECK_EN
          if (is_misaligned(in_sz, in_off)) begin
            state_d     = LSU_IDLE;
            mis_valid_d = 1'b1;
            mis_addr_d  = ls_address;
          end
`endif
        end
      end
      LSU_REQ: begin
        if (flush) state_d = LSU_IDLE;
        else if (mem_req_ready) state_d = LSU_WAIT;
      end
      LSU_WAIT: begin
        // A flush arriving with the response still kills the writeback.
        if (mem_resp_valid) begin
          state_d = LSU_IDLE;
          if (load_q && !flush) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = ext_data;
          end
        end else if (flush) begin
          state_d = LSU_DRAIN;
        end
      end
      LSU_DRAIN: begin
        if (mem_resp_valid) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= LSU_IDLE;
      size_q     <= SZ_B;
      off_q      <= '0;
      unsigned_q <= 1'b0;
      load_q     <= 1'b0;
      rd_q       <= '0;
      req_addr_q <= '0;
      wen_q      <= 1'b0;
      wmask_q    <= '0;
      wdata_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      mis_valid_q <= 1'b0;
      mis_addr_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      off_q      <= off_d;
      unsigned_q <= unsigned_d;
      load_q     <= load_d;
      rd_q       <= rd_d;
      req_addr_q <= req_addr_d;
      wen_q      <= wen_d;
      wmask_q    <= wmask_d;
      wdata_q    <= wdata_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
`ifdef LSU_MISALIGN_CHECK_EN
      mis_valid_q <= mis_valid_d;
      mis_addr_q  <= mis_addr_d;
`endif
    end
  end

  assign in_ready      = (state_q == LSU_IDLE);
  assign mem_req_valid = (state_q == LSU_REQ);
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wmask = wmask_q;
  assign mem_req_wdata = wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign_valid = mis_valid_q;
  assign misalign_addr  = mis_addr_q;
`else
  assign misalign_valid = 1'b0;
  assign misalign_addr  = '0;
`endif

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed accesses push expected memory requests
// and writebacks; a negedge monitor pops and compares them.
module tb_lsu;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, is_load, is_store, is_unsigned, flush;
  logic [3:0]  ls_size;
  logic [63:0] ls_address, store_data;
  logic [4:0]  rd;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        misalign_valid;
  logic [63:0] misalign_addr;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [7:0]  mask;
    logic [63:0] data;
  } req_t;
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } wb_t;

  req_t req_q[$];
  wb_t  wb_q[$];
  int   checks = 0;
  int   errors = 0;

  lsu #(.DATA_WIDTH(64)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .is_load(is_load), .is_store(is_store), .ls_size(ls_size),
    .is_unsigned(is_unsigned), .ls_address(ls_address),
    .store_data(store_data), .rd(rd), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wmask(mem_req_wmask), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_valid(misalign_valid), .misalign_addr(misalign_addr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [3:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] data, input logic [4:0] r);
    in_valid    = 1'b1;
    is_load     = ld;
    is_store    = ~ld;
    ls_size     = sz;
    is_unsigned = uns;
    ls_address  = addr;
    store_data  = data;
    rd          = r;
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (mem_req_valid && mem_req_ready && !flush) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req actual=%h expected=none", mem_req_addr);
        end else begin
          req_t e;
          e = req_q.pop_front();
          chk("req_addr", mem_req_addr, e.addr);
          chk("req_wen", 64'(mem_req_wen), 64'(e.wen));
          chk("req_wmask", 64'(mem_req_wmask), 64'(e.mask));
          chk("req_wdata", mem_req_wdata, e.data);
        end
      end
      if (wb_valid) begin
        if (wb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wb actual=%h expected=none", wb_data);
        end else begin
          wb_t w;
          w = wb_q.pop_front();
          chk("wb_rd", 64'(wb_rd), 64'(w.rd));
          chk("wb_data", wb_data, w.data);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    ls_size = 4'b0; is_unsigned = 1'b0; ls_address = '0; store_data = '0;
    rd = '0; flush = 1'b0; mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    step(); step();
    @(negedge clock);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_req_addr", mem_req_addr, 64'd0);
    chk("rst_mis_valid", 64'(misalign_valid), 64'd0);
    reset_n = 1'b1;
    step();

    // load word signed, immediate ready and response
    drive(1'b1, 4'b0100, 1'b0, 64'h1004, 64'h0, 5'd5);
    req_q.push_back('{addr: 64'h1000, wen: 1'b0, mask: 8'hF0, data: 64'h0});
    wb_q.push_back('{rd: 5'd5, data: 64'hFFFFFFFF_80000000});
    step(); in_valid = 1'b0;
    step(); mem_resp_valid = 1'b1; mem_resp_rdata = 64'h80000000_00000000;
    @(negedge clock); chk("a_in_ready_wait", 64'(in_ready), 64'd0);
    step(); mem_resp_valid = 1'b0;
    @(negedge clock);
    chk("a_wb_cycle3", 64'(wb_valid), 64'd1);
    chk("a_in_ready_back", 64'(in_ready), 64'd1);
    step();
    @(negedge clock); chk("a_wb_pulse", 64'(wb_valid), 64'd0);

    // store half
    drive(1'b0, 4'b0010, 1'b0, 64'h2006, 64'hABCD, 5'd0);
    req_q.push_back('{addr: 64'h2000, wen: 1'b1, mask: 8'hC0, data: 64'hABCD0000_00000000});
    step(); in_valid = 1'b0;
    step(); mem_resp_valid = 1'b1; mem_resp_rdata = 64'h0;
    step(); mem_resp_valid = 1'b0;
    @(negedge clock);
    chk("b_no_wb", 64'(wb_valid), 64'd0);
    chk("b_in_ready", 64'(in_ready), 64'd1);

    // load byte unsigned with ready held low for 4 cycles
    mem_req_ready = 1'b0;
    drive(1'b1, 4'b0001, 1'b1, 64'h3003, 64'h0, 5'd7);
    req_q.push_back('{addr: 64'h3000, wen: 1'b0, mask: 8'h08, data: 64'h0});
    wb_q.push_back('{rd: 5'd7, data: 64'h0000_00FE});
    step(); in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("c_hold_valid", 64'(mem_req_valid), 64'd1);
      chk("c_hold_addr", mem_req_addr, 64'h3000);
      chk("c_hold_mask", 64'(mem_req_wmask), 64'h08);
      step();
    end
    mem_req_ready = 1'b1;
    step(); mem_resp_valid = 1'b1; mem_resp_rdata = 64'h00000000_FE000000;
    step(); mem_resp_valid = 1'b0;
    @(negedge clock); chk("c_wb", 64'(wb_valid), 64'd1);

    // flush in WAIT, response two cycles later
    drive(1'b1, 4'b0100, 1'b0, 64'h10, 64'h0, 5'd3);
    req_q.push_back('{addr: 64'h10, wen: 1'b0, mask: 8'h0F, data: 64'h0});
    step(); in_valid = 1'b0;
    step(); flush = 1'b1;
    step(); flush = 1'b0;
    @(negedge clock); chk("d_drain_busy", 64'(in_ready), 64'd0);
    step(); mem_resp_valid = 1'b1; mem_resp_rdata = 64'hFFFFFFFF_FFFFFFFF;
    @(negedge clock); chk("d_drain_resp", 64'(in_ready), 64'd0);
    step(); mem_resp_valid = 1'b0;
    @(negedge clock);
    chk("d_in_ready", 64'(in_ready), 64'd1);
    chk("d_no_wb", 64'(wb_valid), 64'd0);

    // flush in REQ beats a same-cycle ready
    drive(1'b1, 4'b1000, 1'b0, 64'h20, 64'h0, 5'd4);
    step(); in_valid = 1'b0; flush = 1'b1;
    step(); flush = 1'b0;
    @(negedge clock);
    chk("e_flush_idle", 64'(in_ready), 64'd1);
    chk("e_no_req", 64'(mem_req_valid), 64'd0);
    step();
    @(negedge clock); chk("e_no_wb", 64'(wb_valid), 64'd0);

    // misaligned load double
`ifdef LSU_MISALIGN_CHECK_EN
    drive(1'b1, 4'b1000, 1'b0, 64'h4004, 64'h0, 5'd9);
    step(); in_valid = 1'b0;
    @(negedge clock);
    chk("f_mis_valid", 64'(misalign_valid), 64'd1);
    chk("f_mis_addr", misalign_addr, 64'h4004);
    chk("f_no_req", 64'(mem_req_valid), 64'd0);
    step();
    @(negedge clock);
    chk("f_mis_pulse", 64'(misalign_valid), 64'd0);
    chk("f_in_ready", 64'(in_ready), 64'd1);
`else
    drive(1'b1, 4'b1000, 1'b0, 64'h4004, 64'h0, 5'd9);
    req_q.push_back('{addr: 64'h4000, wen: 1'b0, mask: 8'hFF, data: 64'h0});
    wb_q.push_back('{rd: 5'd9, data: 64'h00000000_11223344});
    step(); in_valid = 1'b0;
    @(negedge clock); chk("f_mis_off", 64'(misalign_valid), 64'd0);
    step(); mem_resp_valid = 1'b1; mem_resp_rdata = 64'h11223344_55667788;
    step(); mem_resp_valid = 1'b0;
    @(negedge clock); chk("f_wb", 64'(wb_valid), 64'd1);
`endif

    // back-to-back loads
    step();
    drive(1'b1, 4'b1000, 1'b0, 64'h0, 64'h0, 5'd1);
    req_q.push_back('{addr: 64'h0, wen: 1'b0, mask: 8'hFF, data: 64'h0});
    wb_q.push_back('{rd: 5'd1, data: 64'h01234567_89ABCDEF});
    step(); in_valid = 1'b0;
    step(); mem_resp_valid = 1'b1; mem_resp_rdata = 64'h01234567_89ABCDEF;
    step(); mem_resp_valid = 1'b0;
    drive(1'b1, 4'b1000, 1'b0, 64'h8, 64'h0, 5'd2);
    req_q.push_back('{addr: 64'h8, wen: 1'b0, mask: 8'hFF, data: 64'h0});
    wb_q.push_back('{rd: 5'd2, data: 64'hFEDCBA98_76543210});
    @(negedge clock);
    chk("g_ready_with_wb", 64'(in_ready), 64'd1);
    chk("g_wb_first", 64'(wb_valid), 64'd1);
    step(); in_valid = 1'b0;
    @(negedge clock); chk("g_second_req", 64'(mem_req_valid), 64'd1);
    step(); mem_resp_valid = 1'b1; mem_resp_rdata = 64'hFEDCBA98_76543210;
    step(); mem_resp_valid = 1'b0;
    @(negedge clock); chk("g_wb_second", 64'(wb_valid), 64'd1);

    // reset while waiting for a response
    drive(1'b1, 4'b1000, 1'b0, 64'h30, 64'h0, 5'd6);
    req_q.push_back('{addr: 64'h30, wen: 1'b0, mask: 8'hFF, data: 64'h0});
    step(); in_valid = 1'b0;
    step(); reset_n = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 64'h55;
    step(); reset_n = 1'b1; mem_resp_valid = 1'b0;
    @(negedge clock);
    chk("h_rst_idle", 64'(in_ready), 64'd1);
    chk("h_rst_no_wb", 64'(wb_valid), 64'd0);
    step();
    @(negedge clock); chk("h_rst_no_wb2", 64'(wb_valid), 64'd0);

    step();
    chk("req_queue_empty", 64'(req_q.size()), 64'd0);
    chk("wb_queue_empty", 64'(wb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
